// File: rtl/steer_en.sv
// Rider-detect / steering-enable FSM for the balance platform.
// Registers the load cells, checks total weight and left/right balance, and gates steering after a dwell.
module steer_en #(
    parameter logic [11:0] MIN_RIDER_WT = 12'h200,
    parameter logic [11:0] WT_HYST      = 12'h040,
    parameter int          TMR_W        = 26
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [11:0] lft_ld,
    input  logic [11:0] rght_ld,
    output logic        en_steer,
    output logic        rider_off
);

    localparam int DATA_W = 12;
    localparam logic [DATA_W:0] THR_HI = {1'b0, MIN_RIDER_WT} + {1'b0, WT_HYST};
    localparam logic [DATA_W:0] THR_LO = {1'b0, MIN_RIDER_WT} - {1'b0, WT_HYST};

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        STEER_EN
    } state_t;

    state_t state, nxt_state;

    logic [DATA_W-1:0] lft_q, rght_q;
    logic [DATA_W:0]   sum;
    logic [DATA_W-1:0] diff;
    logic [DATA_W+1:0] diff_x4;
    logic [DATA_W+4:0] diff_x16, sum_x15;
    logic              sum_gt_min, sum_lt_min, diff_gt_1_4, diff_gt_15_16;
    logic [TMR_W-1:0]  tmr;
    logic              tmr_full, clr_tmr;

    function automatic logic [TMR_W-1:0] sat_inc(input logic [TMR_W-1:0] v);
        return (&v) ? v : v + TMR_W'(1);
    endfunction

    // Input register stage
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lft_q  <= '0;
            rght_q <= '0;
        end else begin
            lft_q  <= lft_ld;
            rght_q <= rght_ld;
        end
    end

    assign sum      = {1'b0, lft_q} + {1'b0, rght_q};
    assign diff     = (lft_q >= rght_q) ? (lft_q - rght_q) : (rght_q - lft_q);
    assign diff_x4  = {diff, 2'b00};
    assign diff_x16 = {1'b0, diff, 4'b0000};
    assign sum_x15  = {sum, 4'b0000} - {4'b0000, sum};

    assign sum_gt_min    = sum > THR_HI;
    assign sum_lt_min    = sum < THR_LO;
    assign diff_gt_1_4   = diff_x4 > {1'b0, sum};
    assign diff_gt_15_16 = diff_x16 > sum_x15;

    // Dwell timer, saturating so a long balanced WAIT cannot wrap
    always_ff @(posedge clk) begin
        if (!rst_n)       tmr <= '0;
        else if (clr_tmr) tmr <= '0;
        else              tmr <= sat_inc(tmr);
    end

    assign tmr_full = &tmr;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= nxt_state;
    end

    always_comb begin
        nxt_state = state;
        clr_tmr   = 1'b0;
        case (state)
            IDLE: begin
                if (sum_gt_min) begin
                    nxt_state = WAIT;
                    clr_tmr   = 1'b1;
                end
            end
            WAIT: begin
                if (sum_lt_min)       nxt_state = IDLE;
                else if (diff_gt_1_4) clr_tmr   = 1'b1;
                else if (tmr_full)    nxt_state = STEER_EN;
            end
            STEER_EN: begin
                // Exit lean limit is looser than entry so normal leaning keeps steering
                if (sum_lt_min) nxt_state = IDLE;
                else if (diff_gt_15_16) begin
                    nxt_state = WAIT;
                    clr_tmr   = 1'b1;
                end
            end
            default: nxt_state = IDLE;
        endcase
    end

    assign en_steer  = (state == STEER_EN);
    assign rider_off = (state == IDLE);

endmodule

// File: tb/tb_steer_en.sv
// Directed bench for steer_en with a 16-cycle dwell (TMR_W=4).
module tb_steer_en;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [11:0] lft_ld, rght_ld;
    logic        en_steer, rider_off;

    int vectors     = 0;
    int miscompares = 0;

    steer_en #(
        .MIN_RIDER_WT(12'h200),
        .WT_HYST     (12'h040),
        .TMR_W       (4)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .lft_ld   (lft_ld),
        .rght_ld  (rght_ld),
        .en_steer (en_steer),
        .rider_off(rider_off)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic exp_off, input logic exp_en);
        check({tag, ".rider_off"}, rider_off, exp_off);
        check({tag, ".en_steer"}, en_steer, exp_en);
    endtask

    task automatic set_ld(input logic [11:0] l, input logic [11:0] r);
        lft_ld  = l;
        rght_ld = r;
    endtask

    initial begin
        // Reset with arbitrary heavy loads present
        rst_n = 1'b0;
        set_ld(12'h3FF, 12'h3FF);
        tick(2);
        chk_out("reset", 1'b1, 1'b0);

        // Sum exactly on the upper threshold: no entry
        set_ld(12'h120, 12'h120);
        rst_n = 1'b1;
        tick(20);
        chk_out("idle_sum_240", 1'b1, 1'b0);

        // Sum 0x260: WAIT entry on 2nd edge, STEER_EN 16 edges later
        set_ld(12'h130, 12'h130);
        tick(1);
        chk_out("entry_edge1", 1'b1, 1'b0);
        tick(1);
        chk_out("entry_wait", 1'b0, 1'b0);
        tick(15);
        chk_out("dwell_15", 1'b0, 1'b0);
        tick(1);
        chk_out("dwell_16", 1'b0, 1'b1);

        // Lean inside the 15/16 limit keeps steering
        set_ld(12'h2F0, 12'h020);
        tick(5);
        chk_out("lean_ok", 1'b0, 1'b1);

        // Hard lean drops back to WAIT
        set_ld(12'h300, 12'h008);
        tick(1);
        chk_out("hard_lean_edge1", 1'b0, 1'b1);
        tick(1);
        chk_out("hard_lean_wait", 1'b0, 1'b0);

        // Re-entry from WAIT: full 16-cycle dwell from the first balanced sample
        set_ld(12'h150, 12'h150);
        tick(16);
        chk_out("reenter_16", 1'b0, 1'b0);
        tick(1);
        chk_out("reenter_17", 1'b0, 1'b1);

        // Step-off: sum 0x1C0 is inside the band, 0x1B0 is below it
        set_ld(12'h0E0, 12'h0E0);
        tick(5);
        chk_out("band_1c0", 1'b0, 1'b1);
        set_ld(12'h0D8, 12'h0D8);
        tick(1);
        chk_out("stepoff_edge1", 1'b0, 1'b1);
        tick(1);
        chk_out("stepoff_idle", 1'b1, 1'b0);

        // Imbalance holds WAIT without advancing the dwell
        set_ld(12'h200, 12'h0A0);
        tick(2);
        chk_out("imbal_wait", 1'b0, 1'b0);
        tick(40);
        chk_out("imbal_40", 1'b0, 1'b0);
        set_ld(12'h150, 12'h150);
        tick(16);
        chk_out("rebal_16", 1'b0, 1'b0);
        tick(1);
        chk_out("rebal_17", 1'b0, 1'b1);

        // Step-off from WAIT
        set_ld(12'h300, 12'h008);
        tick(2);
        chk_out("to_wait", 1'b0, 1'b0);
        set_ld(12'h0D8, 12'h0D8);
        tick(1);
        chk_out("wait_stepoff_edge1", 1'b0, 1'b0);
        tick(1);
        chk_out("wait_stepoff_idle", 1'b1, 1'b0);

        // Reset mid-STEER_EN, then confirm a fresh full dwell
        set_ld(12'h150, 12'h150);
        tick(18);
        chk_out("pre_reset_steer", 1'b0, 1'b1);
        rst_n = 1'b0;
        tick(1);
        chk_out("reset_mid_steer", 1'b1, 1'b0);
        rst_n = 1'b1;
        tick(1);
        chk_out("post_reset_edge1", 1'b1, 1'b0);
        tick(1);
        chk_out("post_reset_wait", 1'b0, 1'b0);
        tick(15);
        chk_out("post_reset_dwell15", 1'b0, 1'b0);
        tick(1);
        chk_out("post_reset_dwell16", 1'b0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
